// File: rtl/parking_exit_controller_pkg.sv
// Shared definitions for the parking exit/entrance controllers:
// FSM state encoding, status lamp codes and default lot constants.
package parking_exit_controller_pkg;

  localparam int unsigned OCC_W    = 4;
  localparam int unsigned TICKET_W = 3;
  localparam int unsigned LED_W    = 3;

  localparam int unsigned         DEFAULT_CAPACITY  = 7;
  localparam logic [TICKET_W-1:0] DEFAULT_EXIT_CODE = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_TICKET = 3'd1,
    ST_WRONG       = 3'd2,
    ST_OPEN        = 3'd3,
    ST_ALARM       = 3'd4
  } exit_state_e;

  localparam logic [LED_W-1:0] LED_IDLE        = 3'b000;
  localparam logic [LED_W-1:0] LED_WAIT_TICKET = 3'b001;
  localparam logic [LED_W-1:0] LED_WRONG       = 3'b010;
  localparam logic [LED_W-1:0] LED_OPEN        = 3'b100;
  localparam logic [LED_W-1:0] LED_ALARM       = 3'b111;

  // Status lamp code shown for a given controller state.
  function automatic logic [LED_W-1:0] led_for_state(input exit_state_e s);
    logic [LED_W-1:0] led;
    led = LED_IDLE;
    case (s)
      ST_WAIT_TICKET: led = LED_WAIT_TICKET;
      ST_WRONG:       led = LED_WRONG;
      ST_OPEN:        led = LED_OPEN;
      ST_ALARM:       led = LED_ALARM;
      default:        led = LED_IDLE;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/parking_exit_controller_occupancy_counter.sv
// Saturating lot occupancy counter with registered count and full flag.
// Simultaneous increment and decrement cancel out.
module occupancy_counter
  import parking_exit_controller_pkg::*;
#(
  parameter int unsigned CAPACITY = DEFAULT_CAPACITY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] count,
  output logic             full
);

  logic [OCC_W-1:0] r_count;
  logic [OCC_W-1:0] w_count_nxt;
  logic             r_full;

  always_comb begin
    w_count_nxt = r_count;
    if (inc && !dec) begin
      if (r_count != OCC_W'(CAPACITY)) w_count_nxt = r_count + OCC_W'(1);
    end else if (dec && !inc) begin
      if (r_count != '0) w_count_nxt = r_count - OCC_W'(1);
    end
  end

  // Full flag is computed from the next count so it lands with the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == OCC_W'(CAPACITY));
    end
  end

  assign count = r_count;
  assign full  = r_full;

endmodule

// File: rtl/parking_exit_controller.sv
// Exit gate controller: validates exit tickets, times the open gate,
// raises an alarm after repeated wrong codes and tracks lot occupancy.
module parking_exit_controller
  import parking_exit_controller_pkg::*;
#(
  parameter int unsigned         CAPACITY     = DEFAULT_CAPACITY,
  parameter logic [TICKET_W-1:0] EXIT_CODE    = DEFAULT_EXIT_CODE,
  parameter int unsigned         GATE_TIMEOUT = 16,
  parameter int unsigned         MAX_TRIES    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sensor_exit,
  input  logic                sensor_clear,
  input  logic [TICKET_W-1:0] ticket,
  input  logic                ticket_valid,
  input  logic                car_entered,
  output logic                gate_state,
  output logic [LED_W-1:0]    led_state,
  output logic [OCC_W-1:0]    occupancy,
  output logic                lot_full,
  output logic                exit_pulse
);

  localparam int unsigned TMR_W = $clog2(GATE_TIMEOUT + 1);
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  exit_state_e      r_state;
  exit_state_e      w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [TRY_W-1:0] r_tries;
  logic [TRY_W-1:0] w_tries_nxt;
  logic [TRY_W-1:0] w_tries_inc;
  logic             r_clear_q;
  logic             w_clear_rise;
  logic             w_exit_dec;
  logic             r_gate;
  logic [LED_W-1:0] r_led;
  logic             r_exit_pulse;

  assign w_clear_rise = sensor_clear & ~r_clear_q;
  assign w_tries_inc  = r_tries + TRY_W'(1);

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_tries      <= '0;
      r_clear_q    <= 1'b0;
      r_gate       <= 1'b0;
      r_led        <= LED_IDLE;
      r_exit_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_tries      <= w_tries_nxt;
      r_clear_q    <= sensor_clear;
      r_gate       <= (w_state_nxt == ST_OPEN);
      r_led        <= led_for_state(w_state_nxt);
      r_exit_pulse <= w_exit_dec;
    end
  end

  // Next-state logic; a ticket strobe outranks the car leaving the loop.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_tries_nxt = r_tries;
    w_exit_dec  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (sensor_exit) w_state_nxt = ST_WAIT_TICKET;
      end
      ST_WAIT_TICKET, ST_WRONG: begin
        if (ticket_valid) begin
          if (ticket == EXIT_CODE) begin
            w_state_nxt = ST_OPEN;
            w_tries_nxt = '0;
            w_timer_nxt = TMR_W'(GATE_TIMEOUT);
          end else if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
            w_state_nxt = ST_ALARM;
            w_tries_nxt = w_tries_inc;
          end else begin
            w_state_nxt = ST_WRONG;
            w_tries_nxt = w_tries_inc;
          end
        end else if (!sensor_exit) begin
          w_state_nxt = ST_IDLE;
          w_tries_nxt = '0;
        end
      end
      ST_OPEN: begin
        if (w_clear_rise) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
          w_exit_dec  = 1'b1;
        end else if (r_timer <= TMR_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_ALARM: begin
        if (!sensor_exit) begin
          w_state_nxt = ST_IDLE;
          w_tries_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_tries_nxt = '0;
      end
    endcase
  end

  occupancy_counter #(
    .CAPACITY(CAPACITY)
  ) u_occupancy (
    .clk  (clk),
    .reset(reset),
    .inc  (car_entered),
    .dec  (w_exit_dec),
    .count(occupancy),
    .full (lot_full)
  );

  assign gate_state = r_gate;
  assign led_state  = r_led;
  assign exit_pulse = r_exit_pulse;

endmodule
